// File: rtl/add_sub_seq_if.sv
// add_sub_seq_if: operand/result valid-ready bundle for the digit-serial adder/subtractor
interface add_sub_seq_if #(parameter int WIDTH = 8);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic sub;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;
  logic zero;
  modport master(output in_valid, a, b, cin, sub, out_ready,
                 input in_ready, out_valid, sum, cout, ovf, zero);
  modport slave(input in_valid, a, b, cin, sub, out_ready,
                output in_ready, out_valid, sum, cout, ovf, zero);
endinterface

// File: rtl/add_sub_seq.sv
// add_sub_seq: digit-serial adder/subtractor, DIGIT full-adder cells per cycle with overflow/zero flags
module add_sub_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic clk,
  input logic rst,
  add_sub_seq_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("add_sub_seq: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nxt;
  logic [DIGIT-1:0] da, db, dsum;
  logic [KW-1:0] k;
  logic c_r, cr, cm, cout_r, ovf_r, zero_r, last;
  always_comb begin
    da = a_r[k*DIGIT +: DIGIT];
    db = b_r[k*DIGIT +: DIGIT];
    dsum = '0;
    cr = c_r;
    cm = c_r;
    for (int i = 0; i < DIGIT; i++) begin
      cm = cr;
      dsum[i] = da[i] ^ db[i] ^ cr;
      cr = (da[i] & db[i]) | (cr & (da[i] ^ db[i]));
    end
    sum_nxt = sum_r;
    sum_nxt[k*DIGIT +: DIGIT] = dsum;
  end
  assign last = k == KW'(N - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (bus.in_valid ? BUSY : IDLE) :
                state == BUSY ? (last ? DONE : BUSY) :
                (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      k <= '0;
      c_r <= 1'b0;
      cout_r <= 1'b0;
      ovf_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.in_valid) begin
        a_r <= bus.a;
        b_r <= bus.sub ? ~bus.b : bus.b;
        c_r <= bus.sub ^ bus.cin;
        k <= '0;
      end
      if (state == BUSY) begin
        sum_r <= sum_nxt;
        c_r <= cr;
        k <= k + KW'(1);
        if (last) begin
          cout_r <= cr;
          ovf_r <= cr ^ cm;
          zero_r <= sum_nxt == '0;
        end
      end
    end
  end
  assign bus.in_ready = state == IDLE && !rst;
  assign bus.out_valid = state == DONE;
  assign bus.sum = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf = ovf_r;
  assign bus.zero = zero_r;
endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: directed and sweep checks of add_sub_seq against an arithmetic reference model
module tb_add_sub_seq;
  logic clk = 0;
  logic rst = 1;
  logic iv = 0, ordy = 1, rnd = 0, rnd_bit = 1, cin_v = 0, sub_v = 0;
  logic [7:0] a_v = 0, b_v = 0;
  int sel = 0, cyc = 0, tests = 0, fails = 0;
  typedef struct packed {logic [7:0] s; logic c; logic o; logic z;} exp_t;
  exp_t eq[3][$];
  int tq[3][$];
  bit pv[3];
  wire ordy_eff = rnd ? rnd_bit : ordy;
  add_sub_seq_if #(.WIDTH(8)) i0();
  add_sub_seq_if #(.WIDTH(4)) i1();
  add_sub_seq_if #(.WIDTH(8)) i2();
  add_sub_seq #(.WIDTH(8), .DIGIT(2)) d0(.clk(clk), .rst(rst), .bus(i0));
  add_sub_seq #(.WIDTH(4), .DIGIT(1)) d1(.clk(clk), .rst(rst), .bus(i1));
  add_sub_seq #(.WIDTH(8), .DIGIT(8)) d2(.clk(clk), .rst(rst), .bus(i2));
  assign i0.in_valid = iv && sel == 0;
  assign i1.in_valid = iv && sel == 1;
  assign i2.in_valid = iv && sel == 2;
  assign i0.a = a_v;
  assign i0.b = b_v;
  assign i1.a = a_v[3:0];
  assign i1.b = b_v[3:0];
  assign i2.a = a_v;
  assign i2.b = b_v;
  assign i0.cin = cin_v;
  assign i1.cin = cin_v;
  assign i2.cin = cin_v;
  assign i0.sub = sub_v;
  assign i1.sub = sub_v;
  assign i2.sub = sub_v;
  assign i0.out_ready = ordy_eff;
  assign i1.out_ready = ordy_eff;
  assign i2.out_ready = ordy_eff;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) #1 rnd_bit = 1'($urandom_range(0, 1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b, input bit ci, input bit su);
    exp_t e;
    int m, ua, ub, sa, sb, r, sr;
    m = 1 << w;
    ua = int'(a) % m;
    ub = int'(b) % m;
    sa = ua >= m / 2 ? ua - m : ua;
    sb = ub >= m / 2 ? ub - m : ub;
    r = su ? ua - ub - int'(ci) : ua + ub + int'(ci);
    sr = su ? sa - sb - int'(ci) : sa + sb + int'(ci);
    e.s = 8'(((r % m) + m) % m);
    e.c = su ? r >= 0 : r >= m;
    e.o = sr < -(m / 2) || sr >= m / 2;
    e.z = e.s == 0;
    return e;
  endfunction
  task automatic mon(input int i, input int w, input int n, input bit vi, input bit ri, input bit ov,
                     input bit orr, input logic [7:0] s, input bit c, input bit o, input bit z);
    if (ov) begin
      chk($sformatf("pending_op%0d", i), 32'(eq[i].size() > 0), 1);
      if (eq[i].size() > 0) begin
        chk($sformatf("result%0d", i), 32'({s, c, o, z}), 32'(eq[i][0]));
        if (!pv[i]) chk($sformatf("latency%0d", i), cyc - tq[i][0], n);
      end
      chk($sformatf("ready_in_done%0d", i), 32'(ri), 0);
    end
    pv[i] = ov;
    if (rst) begin
      eq[i].delete();
      tq[i].delete();
    end else begin
      if (ov && orr && eq[i].size() > 0) begin
        void'(eq[i].pop_front());
        void'(tq[i].pop_front());
      end
      if (vi && ri) begin
        eq[i].push_back(model(w, a_v, b_v, cin_v, sub_v));
        tq[i].push_back(cyc + 1);
      end
    end
  endtask
  always @(negedge clk) begin
    mon(0, 8, 4, i0.in_valid, i0.in_ready, i0.out_valid, i0.out_ready, i0.sum, i0.cout, i0.ovf, i0.zero);
    mon(1, 4, 4, i1.in_valid, i1.in_ready, i1.out_valid, i1.out_ready, 8'(i1.sum), i1.cout, i1.ovf, i1.zero);
    mon(2, 8, 1, i2.in_valid, i2.in_ready, i2.out_valid, i2.out_ready, i2.sum, i2.cout, i2.ovf, i2.zero);
  end
  function automatic bit rdy(input int s);
    return s == 0 ? i0.in_ready : s == 1 ? i1.in_ready : i2.in_ready;
  endfunction
  task automatic op(input int s, input logic [7:0] a, input logic [7:0] b, input bit ci, input bit su);
    bit got;
    got = 0;
    @(posedge clk);
    #1 sel = s; a_v = a; b_v = b; cin_v = ci; sub_v = su; iv = 1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = rdy(s);
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 iv = 0;
  endtask
  task automatic wait_valid();
    bit got;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = i0.out_valid;
    end
    if (!got) chk("valid_timeout", 0, 1);
  endtask
  task automatic drain(input int s);
    bit done;
    done = 0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = eq[s].size() == 0;
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask
  task automatic dir(input string nm, input logic [7:0] a, input logic [7:0] b, input bit ci, input bit su,
                     input logic [7:0] es, input bit ec, input bit eo, input bit ez);
    ordy = 0;
    op(0, a, b, ci, su);
    wait_valid();
    chk(nm, 32'({i0.sum, i0.cout, i0.ovf, i0.zero}), 32'({es, ec, eo, ez}));
    @(posedge clk);
    #1 ordy = 1;
    drain(0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready0", 32'(i0.in_ready), 0);
    chk("rst_in_ready1", 32'(i1.in_ready), 0);
    chk("rst_in_ready2", 32'(i2.in_ready), 0);
    chk("rst_outputs", 32'({i0.out_valid, i0.sum, i0.cout, i0.ovf, i0.zero}), 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("idle_ready", 32'(i0.in_ready), 1);
    chk("pin_add_ovf", 32'(model(8, 8'h7F, 8'h01, 0, 0)), 32'({8'h80, 1'b0, 1'b1, 1'b0}));
    chk("pin_sub_borrow", 32'(model(8, 8'h05, 8'h07, 0, 1)), 32'({8'hFE, 1'b0, 1'b0, 1'b0}));
    chk("pin_sub_ovf", 32'(model(8, 8'h80, 8'h01, 0, 1)), 32'({8'h7F, 1'b1, 1'b1, 1'b0}));
    chk("pin_w4", 32'(model(4, 8'h07, 8'h01, 0, 0)), 32'({8'h08, 1'b0, 1'b1, 1'b0}));
    dir("add_7f_01", 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0);
    dir("add_ff_01", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1);
    dir("add_ff_ff_c", 8'hFF, 8'hFF, 1, 0, 8'hFF, 1, 0, 0);
    dir("sub_05_07", 8'h05, 8'h07, 0, 1, 8'hFE, 0, 0, 0);
    dir("sub_80_01", 8'h80, 8'h01, 0, 1, 8'h7F, 1, 1, 0);
    dir("sub_05_02_b", 8'h05, 8'h02, 1, 1, 8'h02, 1, 0, 0);
    ordy = 0;
    op(0, 8'h12, 8'h34, 0, 0);
    wait_valid();
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      #1 sel = 0; a_v = 8'hAA; b_v = 8'h55; cin_v = 1; sub_v = 1; iv = 1;
      @(negedge clk);
      chk("stall_ready", 32'(i0.in_ready), 0);
      chk("stall_hold", 32'({i0.out_valid, i0.sum, i0.cout, i0.ovf, i0.zero}), 32'({1'b1, 8'h46, 3'b000}));
    end
    @(posedge clk);
    #1 iv = 0; ordy = 1;
    @(posedge clk);
    @(negedge clk);
    chk("release_state", 32'({i0.out_valid, i0.in_ready}), 32'(2'b01));
    chk("single_xfer", eq[0].size(), 0);
    op(0, 8'h33, 8'h44, 0, 0);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_gates_ready", 32'(i0.in_ready), 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midop_rst_out", 32'({i0.out_valid, i0.sum, i0.cout, i0.ovf, i0.zero}), 0);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk("midop_no_valid", 32'(i0.out_valid), 0);
    end
    dir("post_rst", 8'h10, 8'h20, 0, 0, 8'h30, 0, 0, 0);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            op(1, 8'(x), 8'(y), c[0], s[0]);
    drain(1);
    rnd = 1;
    for (int t = 0; t < 1000; t++)
      op(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    drain(2);
    rnd = 0;
    chk("final_q0", eq[0].size(), 0);
    chk("final_q1", eq[1].size(), 0);
    chk("final_q2", eq[2].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
